// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmit framer with a one-deep holding register.
// Serialises start, LSB-first data, optional parity and one or two stop
// bits onto tx, advancing one bit per baud_tick. Parity is generated here
// when a word moves from the holding register into the shift register.
module uart_tx_framer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        parity_type,
    input  logic              stop2,
    output logic              tx,
    output logic              busy,
    output logic              parity_bit,
    output logic              frame_done
);

    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t            state_reg, state_next;

    // Holding register: the word waiting for the line
    logic [DATA_W-1:0] hold_data_reg, hold_data_next;
    logic [1:0]        hold_ptype_reg, hold_ptype_next;
    logic              hold_stop2_reg, hold_stop2_next;
    logic              hold_full_reg, hold_full_next;

    // Frame in flight: configuration is latched here so input changes
    // mid-frame cannot disturb it
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              ins_parity_reg, ins_parity_next;
    logic              cur_stop2_reg, cur_stop2_next;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;

    logic              parity_reg, parity_next;
    logic              tx_reg, tx_next;
    logic              done_reg, done_next;

    logic              accept;
    logic              load;
    logic              end_frame;
    logic              hold_parity;

    // XOR reduction of the held word, built as an explicit chain
    logic [DATA_W:0]   xor_chain;

    assign xor_chain[0] = 1'b0;

    genvar gi;
    for (gi = 0; gi < DATA_W; gi = gi + 1) begin : g_parity
        assign xor_chain[gi+1] = xor_chain[gi] ^ hold_data_reg[gi];
    end

    // Parity of the held word for its own parity type
    always_comb begin
        hold_parity = 1'b1;
        case (hold_ptype_reg)
            2'b01:   hold_parity = xor_chain[DATA_W];
            2'b10:   hold_parity = ~xor_chain[DATA_W];
            2'b11:   hold_parity = ~xor_chain[DATA_W];
            default: hold_parity = 1'b1;
        endcase
    end

    // The holding register is only offered once reset has been released
    assign in_ready   = !hold_full_reg && !rst;
    assign accept     = in_valid && in_ready;
    assign busy       = (state_reg != S_IDLE);
    assign tx         = tx_reg;
    assign parity_bit = parity_reg;
    assign frame_done = done_reg;

    // Next-state, datapath and registered-output logic
    always_comb begin
        state_next      = state_reg;
        hold_data_next  = hold_data_reg;
        hold_ptype_next = hold_ptype_reg;
        hold_stop2_next = hold_stop2_reg;
        hold_full_next  = hold_full_reg;
        shift_next      = shift_reg;
        ins_parity_next = ins_parity_reg;
        cur_stop2_next  = cur_stop2_reg;
        bit_cnt_next    = bit_cnt_reg;
        parity_next     = parity_reg;
        done_next       = 1'b0;
        load            = 1'b0;
        end_frame       = 1'b0;
        tx_next         = 1'b1;

        if (baud_tick) begin
            case (state_reg)
                S_IDLE: begin
                    if (hold_full_reg) begin
                        load = 1'b1;
                    end
                end
                S_START: begin
                    state_next = S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = ins_parity_reg ? S_PARITY : S_STOP1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        shift_next   = shift_reg >> 1;
                    end
                end
                S_PARITY: begin
                    state_next = S_STOP1;
                end
                S_STOP1: begin
                    if (cur_stop2_reg) begin
                        state_next = S_STOP2;
                    end else begin
                        end_frame = 1'b1;
                    end
                end
                S_STOP2: begin
                    end_frame = 1'b1;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end

        // A finished frame chains straight into the held word if there is one
        if (end_frame) begin
            done_next = 1'b1;
            if (hold_full_reg) begin
                load = 1'b1;
            end else begin
                state_next = S_IDLE;
            end
        end

        // Move the held word into the shift register and fix its parity
        if (load) begin
            state_next      = S_START;
            shift_next      = hold_data_reg;
            ins_parity_next = (hold_ptype_reg == 2'b01) || (hold_ptype_reg == 2'b10);
            cur_stop2_next  = hold_stop2_reg;
            parity_next     = hold_parity;
            bit_cnt_next    = '0;
            hold_full_next  = 1'b0;
        end

        // Acceptance needs an empty holding register, so it never collides
        // with a load; a word accepted on a tick waits for the next tick
        if (accept) begin
            hold_full_next  = 1'b1;
            hold_data_next  = in_data;
            hold_ptype_next = parity_type;
            hold_stop2_next = stop2;
        end

        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = parity_next;
            default:  tx_next = 1'b1;
        endcase
    end

    // State and datapath registers; reset aborts any frame and drops the held word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            hold_data_reg  <= '0;
            hold_ptype_reg <= 2'b00;
            hold_stop2_reg <= 1'b0;
            hold_full_reg  <= 1'b0;
            shift_reg      <= '0;
            ins_parity_reg <= 1'b0;
            cur_stop2_reg  <= 1'b0;
            bit_cnt_reg    <= '0;
            parity_reg     <= 1'b1;
            tx_reg         <= 1'b1;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_data_reg  <= hold_data_next;
            hold_ptype_reg <= hold_ptype_next;
            hold_stop2_reg <= hold_stop2_next;
            hold_full_reg  <= hold_full_next;
            shift_reg      <= shift_next;
            ins_parity_reg <= ins_parity_next;
            cur_stop2_reg  <= cur_stop2_next;
            bit_cnt_reg    <= bit_cnt_next;
            parity_reg     <= parity_next;
            tx_reg         <= tx_next;
            done_reg       <= done_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: two instances (DATA_W=8 and DATA_W=5) share
// clock, reset and baud ticks. A monitor records the line value after every
// tick (2 = line idle) and the tests compare that stream against frames built
// from the framing rules.
module tb_uart_tx_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;

    logic       v8 = 1'b0;
    logic       r8;
    logic [7:0] d8 = '0;
    logic [1:0] p8 = '0;
    logic       s8 = 1'b0;
    logic       tx8, busy8, par8, fd8;

    logic       v5 = 1'b0;
    logic       r5;
    logic [4:0] d5 = '0;
    logic [1:0] p5 = '0;
    logic       s5 = 1'b0;
    logic       tx5, busy5, par5, fd5;

    int checks = 0;
    int failures = 0;

    int q8[$];
    int q5[$];
    int fdc8 = 0;
    int fdc5 = 0;
    int exp_q[$];
    logic tick_q = 1'b0;

    always #5 clk = ~clk;

    uart_tx_framer #(.DATA_W(8)) dut8 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .in_valid(v8), .in_ready(r8), .in_data(d8),
        .parity_type(p8), .stop2(s8),
        .tx(tx8), .busy(busy8), .parity_bit(par8), .frame_done(fd8)
    );

    uart_tx_framer #(.DATA_W(5)) dut5 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick),
        .in_valid(v5), .in_ready(r5), .in_data(d5),
        .parity_type(p5), .stop2(s5),
        .tx(tx5), .busy(busy5), .parity_bit(par5), .frame_done(fd5)
    );

    // Remember whether the last rising edge carried a tick
    always @(posedge clk) tick_q <= baud_tick;

    // Line monitor: one stream entry per tick, frame_done cycles counted
    always @(negedge clk) begin
        if (tick_q) begin
            q8.push_back(busy8 ? int'(tx8) : 2);
            q5.push_back(busy5 ? int'(tx5) : 2);
        end
        if (fd8) fdc8 <= fdc8 + 1;
        if (fd5) fdc5 <= fdc5 + 1;
    end

    // Baud tick generator: single-cycle strobes with random spacing
    initial begin
        forever begin
            @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
            repeat ($urandom_range(2, 4)) @(negedge clk);
        end
    end

    function automatic int qget(input int w, input int i);
        if (w == 8) return (i < q8.size()) ? q8[i] : -1;
        return (i < q5.size()) ? q5[i] : -1;
    endfunction

    function automatic int qsize(input int w);
        return (w == 8) ? q8.size() : q5.size();
    endfunction

    function automatic int fdcount(input int w);
        return (w == 8) ? fdc8 : fdc5;
    endfunction

    // Reference parity from the count of ones in the word
    function automatic int exp_parity(input int w, input int data, input int pt);
        int ones;
        ones = $countones(data & ((1 << w) - 1));
        if (pt == 0) return 1;
        if (pt == 1) return ones % 2;
        return 1 - (ones % 2);
    endfunction

    // Reference frame: start, LSB-first data, parity for types 1/2, stop bit(s)
    task automatic append_frame(input int w, input int data, input int pt, input int s2);
        exp_q.push_back(0);
        for (int i = 0; i < w; i++) exp_q.push_back((data >> i) & 1);
        if (pt == 1 || pt == 2) exp_q.push_back(exp_parity(w, data, pt));
        exp_q.push_back(1);
        if (s2 != 0) exp_q.push_back(1);
    endtask

    task automatic send(input int w, input int data, input int pt, input int s2);
        int n;
        n = 0;
        @(negedge clk);
        if (w == 8) begin
            v8 = 1'b1; d8 = data[7:0]; p8 = pt[1:0]; s8 = s2[0];
        end else begin
            v5 = 1'b1; d5 = data[4:0]; p5 = pt[1:0]; s5 = s2[0];
        end
        while (!((w == 8) ? r8 : r5)) begin
            n++;
            if (n > 2000) begin
                checks++;
                failures++;
                $display("FAIL send_timeout w=%0d in_ready stayed 0, required 1", w);
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        // Scramble the inputs so a frame in flight must not depend on them
        if (w == 8) begin
            v8 = 1'b0; d8 = 8'($urandom); p8 = 2'($urandom); s8 = 1'($urandom);
        end else begin
            v5 = 1'b0; d5 = 5'($urandom); p5 = 2'($urandom); s5 = 1'($urandom);
        end
    endtask

    task automatic wait_frames(input int w, input int target);
        int n;
        n = 0;
        while (fdcount(w) < target) begin
            @(posedge clk);
            n++;
            if (n > 3000) begin
                checks++;
                failures++;
                $display("FAIL frame_timeout w=%0d frame_done count %0d, required %0d", w, fdcount(w), target);
                break;
            end
        end
        repeat (10) @(posedge clk);
    endtask

    task automatic wait_bits(input int w, input int start, input int n);
        int s;
        int k;
        k = 0;
        forever begin
            @(posedge clk);
            s = start;
            while (s < qsize(w) && qget(w, s) == 2) s++;
            if (qsize(w) - s >= n) break;
            k++;
            if (k > 3000) begin
                checks++;
                failures++;
                $display("FAIL bit_timeout w=%0d got %0d bits, required %0d", w, qsize(w) - s, n);
                break;
            end
        end
    endtask

    // Compare the line stream (after leading idle) with exp_q followed by idle
    task automatic check_bits(input string name, input int w, input int start);
        int s;
        int g;
        int e;
        bit bad;
        string gs;
        string es;
        s = start;
        while (s < qsize(w) && qget(w, s) == 2) s++;
        bad = 1'b0;
        gs = "";
        es = "";
        for (int i = 0; i <= exp_q.size(); i++) begin
            g = qget(w, s + i);
            e = (i < exp_q.size()) ? exp_q[i] : 2;
            if (g != e) bad = 1'b1;
            gs = {gs, $sformatf("%0d", g)};
            es = {es, $sformatf("%0d", e)};
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s_bits w=%0d got %s required %s", name, w, gs, es);
        end
        $display("txn %s w=%0d line %s", name, w, gs);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (r8 !== 1'b0)    begin failures++; $display("FAIL reset_ready8 got %b required 0", r8); end
        checks++; if (tx8 !== 1'b1)   begin failures++; $display("FAIL reset_tx8 got %b required 1", tx8); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy8 got %b required 0", busy8); end
        checks++; if (fd8 !== 1'b0)   begin failures++; $display("FAIL reset_done8 got %b required 0", fd8); end
        checks++; if (par8 !== 1'b1)  begin failures++; $display("FAIL reset_parity8 got %b required 1", par8); end
        checks++; if (r5 !== 1'b0)    begin failures++; $display("FAIL reset_ready5 got %b required 0", r5); end
        checks++; if (tx5 !== 1'b1)   begin failures++; $display("FAIL reset_tx5 got %b required 1", tx5); end
        checks++; if (par5 !== 1'b1)  begin failures++; $display("FAIL reset_parity5 got %b required 1", par5); end
        rst = 1'b0;
        #1;
        checks++; if (r8 !== 1'b1)    begin failures++; $display("FAIL release_ready8 got %b required 1", r8); end
        checks++; if (r5 !== 1'b1)    begin failures++; $display("FAIL release_ready5 got %b required 1", r5); end
        $display("txn reset tx8=%b busy8=%b par8=%b ready8=%b", tx8, busy8, par8, r8);
    endtask

    task automatic test_frame(input string name, input int w, input int data, input int pt, input int s2);
        int start;
        int fd0;
        start = qsize(w);
        fd0 = fdcount(w);
        exp_q.delete();
        append_frame(w, data, pt, s2);
        send(w, data, pt, s2);
        wait_frames(w, fd0 + 1);
        check_bits(name, w, start);
        checks++;
        if (fdcount(w) != fd0 + 1) begin
            failures++;
            $display("FAIL %s_done w=%0d got %0d pulse cycles required 1", name, w, fdcount(w) - fd0);
        end
        checks++;
        if (int'((w == 8) ? par8 : par5) != exp_parity(w, data, pt)) begin
            failures++;
            $display("FAIL %s_parity w=%0d got %b required %0d", name, w, (w == 8) ? par8 : par5,
                     exp_parity(w, data, pt));
        end
    endtask

    task automatic test_back_to_back();
        int start;
        int fd0;
        start = q8.size();
        fd0 = fdc8;
        exp_q.delete();
        append_frame(8, 'hA3, 1, 0);
        append_frame(8, 'h3C, 1, 0);
        send(8, 'hA3, 1, 0);
        wait_bits(8, start, 4);
        send(8, 'h3C, 1, 0);
        wait_frames(8, fd0 + 2);
        check_bits("b2b_a3_3c", 8, start);
        checks++;
        if (fdc8 != fd0 + 2) begin
            failures++;
            $display("FAIL b2b_done got %0d pulse cycles required 2", fdc8 - fd0);
        end
        checks++;
        if (int'(par8) != exp_parity(8, 'h3C, 1)) begin
            failures++;
            $display("FAIL b2b_parity got %b required %0d", par8, exp_parity(8, 'h3C, 1));
        end
    endtask

    task automatic test_back_to_back_rand(input int w);
        int start;
        int fd0;
        int data;
        int pt;
        int s2;
        start = qsize(w);
        fd0 = fdcount(w);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            data = $urandom_range(0, (1 << w) - 1);
            pt = $urandom_range(0, 3);
            s2 = $urandom_range(0, 1);
            append_frame(w, data, pt, s2);
            send(w, data, pt, s2);
        end
        wait_frames(w, fd0 + 3);
        check_bits("b2b_rand", w, start);
        checks++;
        if (fdcount(w) != fd0 + 3) begin
            failures++;
            $display("FAIL b2b_rand_done w=%0d got %0d pulse cycles required 3", w, fdcount(w) - fd0);
        end
        checks++;
        if (int'((w == 8) ? par8 : par5) != exp_parity(w, data, pt)) begin
            failures++;
            $display("FAIL b2b_rand_parity w=%0d got %b required %0d", w, (w == 8) ? par8 : par5,
                     exp_parity(w, data, pt));
        end
    endtask

    task automatic test_reset_mid_frame();
        int start;
        int fd0;
        int ridx;
        bit idle_ok;
        start = q8.size();
        fd0 = fdc8;
        send(8, $urandom_range(0, 255), 1, 1);
        wait_bits(8, start, 1);
        send(8, $urandom_range(0, 255), 2, 0);
        wait_bits(8, start, 5);
        @(negedge clk);
        checks++; if (r8 !== 1'b0) begin failures++; $display("FAIL rmid_held got ready %b required 0", r8); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx8 !== 1'b1)   begin failures++; $display("FAIL rmid_tx got %b required 1", tx8); end
        checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL rmid_busy got %b required 0", busy8); end
        @(negedge clk);
        checks++; if (r8 !== 1'b0) begin failures++; $display("FAIL rmid_ready_in_rst got %b required 0", r8); end
        rst = 1'b0;
        #1;
        checks++; if (r8 !== 1'b1) begin failures++; $display("FAIL rmid_ready_after got %b required 1", r8); end
        ridx = q8.size();
        repeat (150) @(posedge clk);
        checks++;
        if (fdc8 != fd0) begin
            failures++;
            $display("FAIL rmid_done got %0d pulse cycles required 0", fdc8 - fd0);
        end
        idle_ok = 1'b1;
        for (int i = ridx; i < q8.size(); i++) if (q8[i] != 2) idle_ok = 1'b0;
        checks++;
        if (!idle_ok) begin
            failures++;
            $display("FAIL rmid_idle line not idle after reset, required idle");
        end
        $display("txn reset_mid_frame ticks_after=%0d done_pulses=%0d", q8.size() - ridx, fdc8 - fd0);
    endtask

    initial begin
        test_reset();
        test_frame("w8_55_even", 8, 'h55, 1, 0);
        test_frame("w8_07_odd_s2", 8, 'h07, 2, 1);
        test_frame("w8_07_type3", 8, 'h07, 3, 0);
        test_frame("w8_07_none", 8, 'h07, 0, 0);
        repeat (8) test_frame("w8_rand", 8, $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 1));
        test_frame("w5_13_even", 5, 'h13, 1, 0);
        repeat (6) test_frame("w5_rand", 5, $urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 1));
        test_back_to_back();
        test_back_to_back_rand(8);
        test_back_to_back_rand(5);
        test_reset_mid_frame();
        test_frame("w8_after_rst", 8, $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 1));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Parametrised UART transmit framer. Accepts a data word plus per-frame parity/stop configuration over a valid/ready handshake and buffers it in a one-deep holding register. It serialises the frame (start, data LSB-first, optional parity, 1 or 2 stop bits) onto `tx`, advancing one bit per `baud_tick`. It sits between the transmit FIFO/host interface and the pad, and replaces the separate combinational parity generator in the transmit path.

## Interface
- `DATA_W`, default 8: data bits per frame. Legal range 5..9.
- `clk` in 1: clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `baud_tick` in 1: one-cycle strobe, one per bit period. Never high on consecutive cycles.
- `in_valid` in 1: `in_data`/`parity_type`/`stop2` are valid.
- `in_ready` out 1: holding register empty; a transfer occurs when `in_valid && in_ready`.
- `in_data` in `DATA_W`: word to send.
- `parity_type` in 2: 00 none; 01 even; 10 odd; 11 odd computed, not inserted.
- `stop2` in 1: 1 = two stop bits, 0 = one.
- `tx` out 1: serial line, idle high.
- `busy` out 1: a frame is on the line (state ≠ IDLE).
- `parity_bit` out 1: parity of the frame currently or last on the line.
- `frame_done` out 1: one-cycle pulse when the last stop bit ends.

## Operation
- Parity function on the data word:
  - 01 even: `^data`.
  - 10 and 11 odd: `~^data`.
  - 00: constant 1.
- Parity is computed and registered into `parity_bit` when the word moves from the holding register to the shift register.
- Holding register:
  - Captures `in_data`, `parity_type` and `stop2` on a handshake.
  - `in_ready = !hold_full`. Mid-frame config changes on the inputs never affect the frame in flight.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2. All transitions occur only on cycles with `baud_tick=1`.
- Transitions:
  - IDLE: tick and `hold_full` → START. The holding register moves to the shift register, `hold_full` clears, `bit_cnt=0`.
  - START: tick → DATA.
  - DATA: tick with `bit_cnt==DATA_W-1` → PARITY if the latched type is 01 or 10, else STOP1. Otherwise `bit_cnt++` and the shift register shifts right.
  - PARITY: tick → STOP1.
  - STOP1: tick → STOP2 if `stop2` is latched. Otherwise it ends the frame.
  - STOP2: tick → ends the frame.
- Frame end:
  - If `hold_full`, go directly to START, loading the next word with no idle gap.
  - Otherwise go to IDLE.
  - `frame_done` pulses in either case.
- `tx` is registered and equals 0 in START, `shift[0]` in DATA, `parity_bit` in PARITY, and 1 in STOP1, STOP2 and IDLE.
- `bit_cnt` width is `$clog2(DATA_W)`. It never wraps beyond `DATA_W-1`.
- Frame length in bit periods: 1 + `DATA_W` + (1 if type is 01/10) + (2 if `stop2`, else 1).

## Timing
- Reset values:
  - `tx=1`, `busy=0`, `frame_done=0`, `parity_bit=1`.
  - `hold_full=0` and state = IDLE.
  - `in_ready=0` while `rst` is high, and 1 from the first cycle after.
- Reset mid-frame aborts the frame. `tx` returns high on the next edge, the held word is discarded, and no `frame_done` is issued.
- Handshake:
  - A word is accepted on the edge where `in_valid && in_ready`. `in_ready` drops on the following cycle.
  - Acceptance may happen in any state, including the same cycle as a tick. In that case the word moves to the shift register on the next tick, not on the current one.
- Latency:
  - The word is accepted at edge A.
  - The first tick after A starts the frame: `tx=0` and `busy=1` from the cycle after that tick's edge.
  - Each later bit changes on the cycle after each tick.
- `frame_done` is high for exactly the one cycle after the tick that ends the last stop bit.
- In the back-to-back case, `in_ready` rises on the cycle after the START load, so a new word may be accepted while the current frame is still in flight.
- `busy` stays high through back-to-back frames.

## Test plan
- **0x55, type 01, `stop2=0`, `DATA_W=8`:** `tx` per tick is 0, 1,0,1,0,1,0,1,0, 0, 1 (11 bits); `parity_bit=0`; one `frame_done`.
- **0x07, type 10, `stop2=1`:** bits 0, 1,1,1,0,0,0,0,0, 0, 1,1 (12 bits); `parity_bit=0`.
- **0x07, type 11:** 10-bit frame with no parity bit; `parity_bit=0`. Type 00 gives a 10-bit frame with `parity_bit=1`.
- **Back-to-back:** 0xA3 then 0x3C, second word presented during the first frame's DATA state. The start bit of 0x3C follows the 0xA3 stop bit with no idle tick, `busy` stays high, and `frame_done` pulses twice.
- **Reset mid-frame:** assert `rst` during DATA bit 3 with a word held. `tx=1` next cycle, `in_ready=1` after release, no `frame_done`, and the held word is never sent.
- **`DATA_W=5`:** 0x13, type 01. Bits 0, 1,1,0,0,1, 1, 1; `parity_bit=1`.
